// File: rtl/aib_rxfifo_rd_ctrl.sv
// AIB receive-FIFO read-side controller: startup phase-compensation delay,
// entry read pointer (binary + Gray) and dword-slot read enables.
module aib_rxfifo_rd_ctrl #(
    parameter int DEPTH  = 16,
    parameter int DEPTH4 = DEPTH * 4
) (
    input  logic                     rd_clk,
    input  logic                     rd_rst,
    input  logic                     rd_start,
    input  logic                     rd_en,
    input  logic [3:0]               r_rd_delay,
    input  logic [1:0]               r_fifo_mode,
    input  logic                     m_gen2_mode,
    output logic [DEPTH4-1:0]        fifo_rd_en,
    output logic [$clog2(DEPTH)-1:0] rd_ptr_gray,
    output logic                     rd_active,
    output logic                     rd_valid
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [1:0]          mode_q, mode_d;
    logic                gen2_q, gen2_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic [DEPTH4-1:0]   fifo_q, fifo_d;
    logic [AW-1:0]       gray_q, gray_d;
    logic                active_q, active_d;
    logic                valid_q, valid_d;
    logic [1:0]          eff_mode;
    logic [3:0]          lanes;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        gen2_d  = gen2_q;
        ptr_d   = ptr_q;
        valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rd_start) begin
                    mode_d  = r_fifo_mode;
                    gen2_d  = m_gen2_mode;
                    cnt_d   = r_rd_delay;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!rd_start) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RUN: begin
                if (!rd_start) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else if (rd_en) begin
                    valid_d = 1'b1;
                    if (mode_q != 2'b11) begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Output registers are loaded from next-state values so they change on
    // the same edge as the pointer/state they describe.
    always_comb begin
        eff_mode = mode_d;
        if (mode_d == 2'b10 && !gen2_d) begin
            eff_mode = 2'b01;
        end

        lanes = 4'b0000;
        unique case (eff_mode)
            2'b00:   lanes = 4'b0001;
            2'b01:   lanes = 4'b0011;
            default: lanes = 4'b1111;
        endcase

        fifo_d = '0;
        if (state_d == ST_RUN) begin
            fifo_d = {{(DEPTH4-4){1'b0}}, lanes} << {ptr_d, 2'b00};
        end

        gray_d   = ptr_d ^ (ptr_d >> 1);
        active_d = (state_d == ST_RUN);
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mode_q   <= '0;
            gen2_q   <= 1'b0;
            ptr_q    <= '0;
            fifo_q   <= '0;
            gray_q   <= '0;
            active_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            gen2_q   <= gen2_d;
            ptr_q    <= ptr_d;
            fifo_q   <= fifo_d;
            gray_q   <= gray_d;
            active_q <= active_d;
            valid_q  <= valid_d;
        end
    end

    assign fifo_rd_en  = fifo_q;
    assign rd_ptr_gray = gray_q;
    assign rd_active   = active_q;
    assign rd_valid    = valid_q;

endmodule

// File: tb/tb_aib_rxfifo_rd_ctrl.sv
// Bench for aib_rxfifo_rd_ctrl: directed scenarios with literal expectations
// plus a cycle-level behavioural model compared on every cycle.
module tb_aib_rxfifo_rd_ctrl;

    localparam int DEPTH  = 16;
    localparam int DEPTH4 = 64;
    localparam int AW     = 4;

    logic              rd_clk = 1'b0;
    logic              rd_rst;
    logic              rd_start;
    logic              rd_en;
    logic [3:0]        r_rd_delay;
    logic [1:0]        r_fifo_mode;
    logic              m_gen2_mode;
    logic [DEPTH4-1:0] fifo_rd_en;
    logic [AW-1:0]     rd_ptr_gray;
    logic              rd_active;
    logic              rd_valid;

    int checks = 0;
    int errors = 0;

    aib_rxfifo_rd_ctrl #(.DEPTH(DEPTH), .DEPTH4(DEPTH4)) dut (
        .rd_clk      (rd_clk),
        .rd_rst      (rd_rst),
        .rd_start    (rd_start),
        .rd_en       (rd_en),
        .r_rd_delay  (r_rd_delay),
        .r_fifo_mode (r_fifo_mode),
        .m_gen2_mode (m_gen2_mode),
        .fifo_rd_en  (fifo_rd_en),
        .rd_ptr_gray (rd_ptr_gray),
        .rd_active   (rd_active),
        .rd_valid    (rd_valid)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge happen, return 1ns after it.
    task automatic applyStimulus(input logic rst, input logic start, input logic en,
                                 input logic [3:0] dly, input logic [1:0] mode,
                                 input logic gen2);
        rd_rst      = rst;
        rd_start    = start;
        rd_en       = en;
        r_rd_delay  = dly;
        r_fifo_mode = mode;
        m_gen2_mode = gen2;
        @(posedge rd_clk);
        #1;
    endtask

    // Behavioural model: phase 0=idle, 1=startup wait, 2=reading.
    int mPhase    = 0;
    int mWaitLeft = 0;
    int mPtr      = 0;
    int mMode     = 0;
    int mGen2     = 0;
    bit mValid    = 0;
    bit mKnown    = 0;

    always @(posedge rd_clk) begin
        mValid = 0;
        if (rd_rst) begin
            mPhase = 0;
            mPtr   = 0;
            mMode  = 0;
            mGen2  = 0;
            mKnown = 1;
        end else if (mPhase == 0) begin
            if (rd_start) begin
                mPhase    = 1;
                mWaitLeft = int'(r_rd_delay) + 1;
                mMode     = int'(r_fifo_mode);
                mGen2     = int'(m_gen2_mode);
            end
        end else if (!rd_start) begin
            mPhase = 0;
            mPtr   = 0;
        end else if (mPhase == 1) begin
            mWaitLeft = mWaitLeft - 1;
            if (mWaitLeft == 0) mPhase = 2;
        end else if (rd_en) begin
            mValid = 1;
            if (mMode != 3) mPtr = (mPtr + 1) % DEPTH;
        end
    end

    function automatic logic [63:0] expFifo();
        int w;
        if (mPhase != 2) return 64'd0;
        if (mMode == 0)      w = 1;
        else if (mMode == 1) w = 2;
        else if (mMode == 2) w = (mGen2 != 0) ? 4 : 2;
        else                 w = 4;
        return ((64'd1 << w) - 64'd1) << (4 * mPtr);
    endfunction

    always @(posedge rd_clk) begin
        #1;
        if (mKnown) begin
            checkOutput("model fifo_rd_en", 64'(fifo_rd_en), expFifo());
            checkOutput("model rd_ptr_gray", 64'(rd_ptr_gray), 64'(mPtr ^ (mPtr >> 1)));
            checkOutput("model rd_active", 64'(rd_active), 64'(mPhase == 2));
            checkOutput("model rd_valid", 64'(rd_valid), 64'(mValid));
        end
    end

    int pulses;
    logic [4:0] pat;

    initial begin
        rd_rst = 1'b1; rd_start = 1'b0; rd_en = 1'b0;
        r_rd_delay = 4'd0; r_fifo_mode = 2'b00; m_gen2_mode = 1'b0;

        // Reset state
        applyStimulus(1, 0, 0, 0, 2'b00, 0);
        applyStimulus(1, 0, 0, 0, 2'b00, 0);
        checkOutput("reset fifo_rd_en", 64'(fifo_rd_en), 64'd0);
        checkOutput("reset rd_ptr_gray", 64'(rd_ptr_gray), 64'd0);
        checkOutput("reset rd_active", 64'(rd_active), 64'd0);
        checkOutput("reset rd_valid", 64'(rd_valid), 64'd0);

        // Startup delay 3, 1:1; delay input changes mid-WAIT must be ignored
        applyStimulus(0, 0, 0, 3, 2'b00, 0);
        checkOutput("idle rd_active", 64'(rd_active), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 1, 0, (k == 1) ? 4'd3 : 4'd0, 2'b00, 0);
            checkOutput("startup wait rd_active", 64'(rd_active), 64'd0);
        end
        applyStimulus(0, 1, 0, 0, 2'b00, 0);
        checkOutput("startup run rd_active", 64'(rd_active), 64'd1);
        checkOutput("startup run fifo_rd_en", 64'(fifo_rd_en), 64'h1);
        applyStimulus(0, 1, 1, 0, 2'b00, 0);
        checkOutput("1:1 step fifo_rd_en", 64'(fifo_rd_en), 64'h10);
        checkOutput("1:1 step gray", 64'(rd_ptr_gray), 64'd1);
        checkOutput("1:1 step rd_valid", 64'(rd_valid), 64'd1);
        applyStimulus(0, 1, 0, 0, 2'b00, 0);
        checkOutput("1:1 hold rd_valid", 64'(rd_valid), 64'd0);

        // 4:1 gen2 with rd_en held for 17 cycles
        applyStimulus(0, 0, 0, 0, 2'b00, 0);
        checkOutput("abort fifo_rd_en", 64'(fifo_rd_en), 64'd0);
        applyStimulus(0, 1, 0, 0, 2'b10, 1);
        applyStimulus(0, 1, 0, 0, 2'b10, 1);
        checkOutput("4:1 first fifo_rd_en", 64'(fifo_rd_en), 64'hF);
        pulses = 0;
        for (int i = 1; i <= 17; i++) begin
            applyStimulus(0, 1, 1, 0, 2'b10, 1);
            pulses += int'(rd_valid);
            if (i == 1) begin
                checkOutput("4:1 ptr1 fifo_rd_en", 64'(fifo_rd_en), 64'hF0);
                checkOutput("4:1 ptr1 gray", 64'(rd_ptr_gray), 64'd1);
            end
            if (i == 15) begin
                checkOutput("4:1 ptr15 fifo_rd_en", 64'(fifo_rd_en), 64'hF000_0000_0000_0000);
                checkOutput("4:1 ptr15 gray", 64'(rd_ptr_gray), 64'd8);
            end
            if (i == 16) begin
                checkOutput("4:1 wrap fifo_rd_en", 64'(fifo_rd_en), 64'hF);
                checkOutput("4:1 wrap gray", 64'(rd_ptr_gray), 64'd0);
            end
        end
        checkOutput("4:1 rd_valid pulses", 64'(pulses), 64'd17);
        applyStimulus(0, 1, 0, 0, 2'b10, 1);
        checkOutput("4:1 idle rd_valid", 64'(rd_valid), 64'd0);

        // Gen1 downgrade of 4:1 to 2:1
        applyStimulus(0, 0, 0, 0, 2'b00, 0);
        applyStimulus(0, 1, 0, 0, 2'b10, 0);
        applyStimulus(0, 1, 0, 0, 2'b10, 0);
        checkOutput("gen1 ptr0 fifo_rd_en", 64'(fifo_rd_en), 64'h3);
        applyStimulus(0, 1, 1, 0, 2'b10, 0);
        checkOutput("gen1 ptr1 fifo_rd_en", 64'(fifo_rd_en), 64'h30);

        // Register mode, delay 1; mode input changes during RUN are ignored
        applyStimulus(0, 0, 0, 0, 2'b00, 0);
        applyStimulus(0, 1, 0, 1, 2'b11, 0);
        checkOutput("reg wait1 rd_active", 64'(rd_active), 64'd0);
        applyStimulus(0, 1, 0, 1, 2'b11, 0);
        checkOutput("reg wait2 rd_active", 64'(rd_active), 64'd0);
        applyStimulus(0, 1, 0, 1, 2'b11, 0);
        checkOutput("reg run fifo_rd_en", 64'(fifo_rd_en), 64'hF);
        pat = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, pat[i], 0, 2'b00, 0);
            checkOutput("reg rd_valid", 64'(rd_valid), 64'(pat[i]));
            checkOutput("reg fifo_rd_en", 64'(fifo_rd_en), 64'hF);
            checkOutput("reg gray", 64'(rd_ptr_gray), 64'd0);
        end

        // Abort at ptr 9, then re-latch delay 0 and 2:1
        applyStimulus(0, 0, 0, 0, 2'b00, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 2, 2'b00, 0);
        checkOutput("abort run fifo_rd_en", 64'(fifo_rd_en), 64'h1);
        for (int i = 0; i < 9; i++) applyStimulus(0, 1, 1, 2, 2'b00, 0);
        checkOutput("abort ptr9 fifo_rd_en", 64'(fifo_rd_en), 64'h10_0000_0000);
        checkOutput("abort ptr9 gray", 64'(rd_ptr_gray), 64'd13);
        applyStimulus(0, 0, 1, 2, 2'b00, 0);
        checkOutput("abort fifo_rd_en", 64'(fifo_rd_en), 64'd0);
        checkOutput("abort gray", 64'(rd_ptr_gray), 64'd0);
        checkOutput("abort rd_active", 64'(rd_active), 64'd0);
        checkOutput("abort rd_valid", 64'(rd_valid), 64'd0);
        applyStimulus(0, 1, 0, 0, 2'b01, 0);
        checkOutput("relatch wait rd_active", 64'(rd_active), 64'd0);
        applyStimulus(0, 1, 0, 0, 2'b01, 0);
        checkOutput("relatch run rd_active", 64'(rd_active), 64'd1);
        checkOutput("relatch fifo_rd_en", 64'(fifo_rd_en), 64'h3);

        // Reset beats rd_en in RUN at ptr 5
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0, 2'b01, 0);
        checkOutput("rst ptr5 fifo_rd_en", 64'(fifo_rd_en), 64'h30_0000);
        checkOutput("rst ptr5 gray", 64'(rd_ptr_gray), 64'd7);
        applyStimulus(1, 1, 1, 0, 2'b01, 0);
        checkOutput("rst fifo_rd_en", 64'(fifo_rd_en), 64'd0);
        checkOutput("rst gray", 64'(rd_ptr_gray), 64'd0);
        checkOutput("rst rd_active", 64'(rd_active), 64'd0);
        checkOutput("rst rd_valid", 64'(rd_valid), 64'd0);
        applyStimulus(0, 1, 0, 0, 2'b00, 0);
        checkOutput("post-rst wait rd_active", 64'(rd_active), 64'd0);
        applyStimulus(0, 1, 0, 0, 2'b00, 0);
        checkOutput("post-rst run fifo_rd_en", 64'(fifo_rd_en), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aib_rxfifo_rd_ctrl.md
AIB_RXFIFO_RD_CTRL -- requirements
Module: aib_rxfifo_rd_ctrl

Interface
REQ-001 The block SHALL take parameter DEPTH, default 16, as the number of FIFO entries; legal values are powers of two, 2 to 32.
REQ-002 The block SHALL take parameter DEPTH4, default DEPTH*4, as the number of 80-bit dword slots.
REQ-003 The block SHALL provide port rd_clk, input, width 1: the single clock; all logic on its rising edge.
REQ-004 The block SHALL provide port rd_rst, input, width 1: reset, synchronous and active-high.
REQ-005 The block SHALL provide port rd_start, input, width 1: level, already synchronized to rd_clk; write side has begun filling the FIFO.
REQ-006 The block SHALL provide port rd_en, input, width 1: read request for the current entry.
REQ-007 The block SHALL provide port r_rd_delay, input, width 4: startup phase-compensation delay in rd_clk cycles.
REQ-008 The block SHALL provide port r_fifo_mode, input, width 2: 00 = 1:1, 01 = 2:1, 10 = 4:1, 11 = register mode.
REQ-009 The block SHALL provide port m_gen2_mode, input, width 1: Gen2 mode.
REQ-010 The block SHALL provide port fifo_rd_en, output, width DEPTH4: dword-slot selector for the read datapath.
REQ-011 The block SHALL provide port rd_ptr_gray, output, width log2(DEPTH): Gray-coded entry read pointer for empty/full comparison.
REQ-012 The block SHALL provide port rd_active, output, width 1: high in RUN state.
REQ-013 The block SHALL provide port rd_valid, output, width 1: marks the cycle in which the datapath output flop holds read data.

Function
REQ-014 The block SHALL implement FSM states IDLE, WAIT and RUN; all outputs SHALL be registered.
REQ-015 In IDLE, when rd_start=1, the FSM SHALL latch r_fifo_mode, m_gen2_mode and r_rd_delay, load the delay counter with r_rd_delay and go to WAIT.
REQ-016 In WAIT, the counter SHALL decrement once per cycle; the FSM SHALL enter RUN on the cycle after the counter reads 0, so delay 0 gives 1 WAIT cycle and delay N gives N+1 WAIT cycles.
REQ-017 In WAIT or RUN, rd_start=0 SHALL return the FSM to IDLE on the next edge, clear the pointer to 0, and force fifo_rd_en=0, rd_active=0 and rd_valid=0 in that same cycle.
REQ-018 Changes to r_fifo_mode, m_gen2_mode or r_rd_delay outside IDLE SHALL be ignored until the next IDLE-to-WAIT transition.
REQ-019 The entry pointer rd_ptr, range 0 to DEPTH-1, SHALL increment by 1 on each rising edge where state=RUN and rd_en=1, wrapping DEPTH-1 to 0.
REQ-020 rd_en SHALL be ignored outside RUN.
REQ-021 fifo_rd_en SHALL be all-zero outside RUN. In RUN, for the current rd_ptr=k:
- 1:1: bit 4k only.
- 2:1: bits 4k and 4k+1.
- 4:1: bits 4k to 4k+3.
REQ-022 When the latched m_gen2_mode=0, a latched mode of 4:1 SHALL be treated as 2:1.
REQ-023 In register mode, rd_ptr SHALL be held at 0, rd_en SHALL NOT advance it, and fifo_rd_en SHALL be 4'hF in bits 3:0 throughout RUN.
REQ-024 fifo_rd_en SHALL update in the same cycle as rd_ptr, so after an advancing edge it reflects the new entry.
REQ-025 rd_ptr_gray SHALL equal rd_ptr ^ (rd_ptr >> 1), registered, updating in the same cycle as rd_ptr.
REQ-026 rd_valid SHALL assert for exactly one cycle following each edge where state=RUN and rd_en=1; this includes register mode.
REQ-027 rd_active SHALL equal (state==RUN).

Reset
REQ-028 When rd_rst=1 at a rising edge, the block SHALL set: state=IDLE, rd_ptr=0, delay counter=0, latched mode=00, latched gen2=0, fifo_rd_en=0, rd_ptr_gray=0, rd_active=0, rd_valid=0.
REQ-029 Reset SHALL take priority over all other inputs, including mid-WAIT and mid-RUN.
REQ-030 Reset SHALL NOT depend on rd_clk-asynchronous paths.

Verification
REQ-031 The bench SHALL cover startup delay: DEPTH=16, r_rd_delay=3, rd_start rises at cycle 0 -> WAIT cycles 1-4, rd_active=1 from cycle 5, fifo_rd_en=0x1.
REQ-032 The bench SHALL cover 4:1 with gen2=1 and rd_en held high for 17 cycles -> fifo_rd_en steps 0xF, 0xF0, ..., bits 63:60, then 0xF; rd_ptr_gray sequence 0,1,3,2,...,8,0; 17 rd_valid pulses.
REQ-033 The bench SHALL cover gen1 downgrade: mode=10, gen2=0 -> fifo_rd_en=0x3 at ptr 0 and 0x30 at ptr 1.
REQ-034 The bench SHALL cover register mode: mode=11 with rd_en toggling -> fifo_rd_en stays 0xF, rd_ptr_gray stays 0, rd_valid follows rd_en delayed 1 cycle.
REQ-035 The bench SHALL cover abort: rd_start drops at ptr=9 in RUN -> next cycle IDLE, fifo_rd_en=0, rd_ptr_gray=0; rd_start re-asserts -> delay and mode re-latched.
REQ-036 The bench SHALL cover reset priority: rd_rst=1 together with rd_en=1 in RUN at ptr=5 -> next cycle all outputs 0 and no rd_valid pulse.
